print_line_fifo: RTL and testbench
==================================

// Module: print_line_fifo
// PURPOSE
//   Stage directly downstream of the printable-char filter. It accepts raw
//   bytes and maps each one through printable: 0x20-0x7e pass unchanged,
//   and every other byte becomes "#" (0x23). Results are buffered in a FIFO
//   and drained to a terminal/UART sink. A CR (0x0D) and LF (0x0A) pair is
//   inserted after every LINE_LEN characters.
// PARAMETERS
//   DEPTH     16  FIFO entries; power of 2, >= 2
//   ADDR_W    4   log2(DEPTH)
//   LINE_LEN  16  printable chars per line before CR/LF; >= 1
// PORTS
//   clk        in   1  single clock; all state changes on posedge
//   rst        in   1  synchronous, active-high reset
//   inByte     in   8  raw byte from upstream
//   inValid    in   1  inByte valid
//   inReady    out  1  FIFO can accept (= ~full); byte accepted when inValid & inReady
//   outChar    out  8  char to sink; 0x00 whenever outValid=0
//   outValid   out  1  outChar valid
//   outReady   in   1  sink accepts; transfer when outValid & outReady
//   subCount   out  8  count of accepted bytes replaced by "#"; saturates at 255
//   lineCount  out  8  completed lines (LF sent); wraps 255->0
// BEHAVIOUR
//   Reset (rst=1 at posedge): rd/wr pointers=0, occupancy=0, state=S_CHAR,
//     colCount=0, subCount=0, lineCount=0. Next cycle: outValid=0,
//     outChar=0x00, inReady=1. FIFO contents and any pending CR/LF are
//     discarded. rst takes priority over every concurrent push or pop.
//   Input: on accept, printable(inByte).pChar is written at wr_ptr, and wr_ptr
//     and occupancy increment. If pValid=0, subCount increments (unless at 255).
//     When full, inReady=0 regardless of outReady; there is no push-through
//     when full.
//   FIFO: show-ahead. The head is combinationally on outChar in S_CHAR.
//     Latency is 1 cycle: a byte accepted at edge N is visible at outChar
//     after edge N. There is no empty bypass.
//     A simultaneous push and pop (not full, not empty) leaves occupancy
//     unchanged. Pointers wrap modulo DEPTH.
//   Output FSM:
//     S_CHAR: outValid = ~empty; outChar = head. On transfer: pop.
//       If colCount==LINE_LEN-1, set colCount=0 and go to S_CR.
//       Otherwise colCount++.
//     S_CR: outValid=1, outChar=0x0D. On transfer go to S_LF. No pop.
//     S_LF: outValid=1, outChar=0x0A. On transfer: lineCount++ and go to
//       S_CHAR. No pop.
//     With outReady=0 the state, outChar and outValid hold stable (no
//     retraction of a valid char). The FIFO keeps accepting input in any state.
//   Order is preserved: output order equals accept order, with CR/LF
//   inserted only at line boundaries. No data is lost or duplicated.
// TESTING
//   1. rst, push 0x41 at edge N, outReady=1 -> after N: outValid=1,
//      outChar=0x41; after N+1: outValid=0, outChar=0x00.
//   2. Push 0x7F, 0x0A, 0x80, 0x7E -> out 0x23, 0x23, 0x23, 0x7E;
//      subCount=3.
//   3. outReady=1, push 16 bytes 0x30..0x3F -> out 0x30..0x3F, 0x0D, 0x0A;
//      lineCount=1; next char starts column 0.
//   4. outReady=0, offer 17 bytes -> 16 accepted, inReady=0 with 17th held
//      upstream. Raise outReady -> 17th accepted one cycle after first pop;
//      order intact.
//   5. In S_CR hold outReady=0 for 5 cycles -> outValid=1, outChar=0x0D
//      stable; then 0x0D, 0x0A transfer.
//   6. rst mid-line (colCount=7, FIFO=5, subCount=2) -> outValid=0, counters=0;
//      next 16 pushes produce CR/LF only after the 16th.

Source files
------------

// File: rtl/print_line_fifo_if.sv
// Handshake bundle between the printable-char filter, the line FIFO and the sink.
// The master side is the producer/sink environment; the slave side is the FIFO.
interface print_line_fifo_if;
  logic [7:0] inByte;
  logic       inValid;
  logic       inReady;
  logic [7:0] outChar;
  logic       outValid;
  logic       outReady;
  logic [7:0] subCount;
  logic [7:0] lineCount;

  modport master (
    output inByte, inValid, outReady,
    input  inReady, outChar, outValid, subCount, lineCount
  );

  modport slave (
    input  inByte, inValid, outReady,
    output inReady, outChar, outValid, subCount, lineCount
  );
endinterface

// File: rtl/print_line_fifo.sv
// Maps raw bytes to printable chars, buffers them in a show-ahead FIFO and
// drains them to a sink, inserting CR/LF after every LINE_LEN characters.
module print_line_fifo #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int LINE_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  print_line_fifo_if.slave  bus
);

  localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_LEN - 1);
  localparam logic [ADDR_W:0]   OCC_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CHAR = 2'd0,
    S_CR   = 2'd1,
    S_LF   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [COL_W-1:0]  r_col;
  logic [7:0]        r_sub;
  logic [7:0]        r_lines;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_line_done;
  logic              w_pvalid;
  logic [7:0]        w_pchar;

  // Non-printable bytes are replaced by '#'; the flag reports whether the byte passed.
  function automatic logic [8:0] printable(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      return {1'b1, b};
    end else begin
      return {1'b0, 8'h23};
    end
  endfunction

  assign {w_pvalid, w_pchar} = printable(bus.inByte);
  assign w_full        = (r_count == OCC_FULL);
  assign w_empty       = (r_count == {(ADDR_W + 1){1'b0}});
  assign w_push        = bus.inValid & ~w_full;
  assign bus.inReady   = ~w_full;
  assign bus.subCount  = r_sub;
  assign bus.lineCount = r_lines;

  // Output FSM next state and combinational output mux.
  always_comb begin
    w_state_next = r_state;
    bus.outValid = 1'b0;
    bus.outChar  = 8'h00;
    w_pop        = 1'b0;
    w_line_done  = 1'b0;
    case (r_state)
      S_CHAR: begin
        if (!w_empty) begin
          bus.outValid = 1'b1;
          bus.outChar  = r_mem[r_rd_ptr];
          if (bus.outReady) begin
            w_pop = 1'b1;
            if (r_col == COL_LAST) begin
              w_state_next = S_CR;
            end else begin
              w_state_next = S_CHAR;
            end
          end else begin
            w_state_next = S_CHAR;
          end
        end else begin
          bus.outValid = 1'b0;
          bus.outChar  = 8'h00;
        end
      end
      S_CR: begin
        bus.outValid = 1'b1;
        bus.outChar  = 8'h0D;
        if (bus.outReady) begin
          w_state_next = S_LF;
        end else begin
          w_state_next = S_CR;
        end
      end
      S_LF: begin
        bus.outValid = 1'b1;
        bus.outChar  = 8'h0A;
        if (bus.outReady) begin
          w_state_next = S_CHAR;
          w_line_done  = 1'b1;
        end else begin
          w_state_next = S_LF;
        end
      end
      default: begin
        w_state_next = S_CHAR;
      end
    endcase
  end

  // State, pointers, occupancy, column and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_CHAR;
      r_wr_ptr <= {ADDR_W{1'b0}};
      r_rd_ptr <= {ADDR_W{1'b0}};
      r_count  <= {(ADDR_W + 1){1'b0}};
      r_col    <= {COL_W{1'b0}};
      r_sub    <= 8'h00;
      r_lines  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(ADDR_W - 1){1'b0}}, 1'b1};
        if (!w_pvalid && r_sub != 8'hFF) begin
          r_sub <= r_sub + 8'h01;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(ADDR_W - 1){1'b0}}, 1'b1};
        r_col    <= (r_col == COL_LAST) ? {COL_W{1'b0}} : r_col + {{(COL_W - 1){1'b0}}, 1'b1};
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{ADDR_W{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{ADDR_W{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
      if (w_line_done) begin
        r_lines <= r_lines + 8'h01;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_pchar;
    end
  end

endmodule

// File: tb/tb_print_line_fifo.sv
// Self-checking bench for print_line_fifo: directed scenarios plus randomized
// traffic compared against a stream-level reference model.
module tb_print_line_fifo;
  localparam int LINE_LEN = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  print_line_fifo_if bus ();

  print_line_fifo #(.DEPTH(16), .ADDR_W(4), .LINE_LEN(LINE_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the complete expected output stream, built at accept time.
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int acc_total;
  int col_m;
  int sub_m;
  int idle_bad;

  function automatic bit is_print(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E);
  endfunction

  function automatic int first_diff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    obs_q.delete();
    acc_total = 0;
    col_m     = 0;
    sub_m     = 0;
    idle_bad  = 0;
  endtask

  // One clock: drive at negedge, sample mid-low phase, record accept/transfer.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy, output logic acc);
    bus.inValid  = v;
    bus.inByte   = b;
    bus.outReady = rdy;
    #1;
    acc = v && bus.inReady;
    if (bus.outValid && rdy) obs_q.push_back(bus.outChar);
    if (!bus.outValid && bus.outChar !== 8'h00) idle_bad++;
    if (acc) begin
      exp_q.push_back(is_print(b) ? b : 8'h23);
      if (!is_print(b) && sub_m < 255) sub_m++;
      acc_total++;
      col_m++;
      if (col_m == LINE_LEN) begin
        col_m = 0;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rdy);
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b1, b, rdy, acc);
      n++;
    end while (!acc && n < 200);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL push_timeout: byte %02h not accepted within %0d cycles", b, n);
    end
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 400) begin
      step(1'b0, 8'h00, 1'b1, acc);
      n++;
    end
    step(1'b0, 8'h00, 1'b1, acc);
  endtask

  task automatic do_reset(input logic v, input logic rdy);
    @(negedge clk);
    bus.inValid  = v;
    bus.inByte   = 8'h99;
    bus.outReady = rdy;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    checks++;
    if (bus.outValid !== 1'b0 || bus.outChar !== 8'h00 || bus.inReady !== 1'b1 ||
        bus.subCount !== 8'h00 || bus.lineCount !== 8'h00) begin
      failures++;
      $display("FAIL reset: got valid=%b char=%02h ready=%b sub=%0d lines=%0d, want 0 00 1 0 0",
               bus.outValid, bus.outChar, bus.inReady, bus.subCount, bus.lineCount);
    end
  endtask

  task automatic test_latency();
    logic acc;
    int d;
    do_reset(1'b0, 1'b0);
    step(1'b1, 8'h41, 1'b1, acc);
    checks++;
    if (bus.outValid !== 1'b1 || bus.outChar !== 8'h41) begin
      failures++;
      $display("FAIL latency_head: got valid=%b char=%02h, want 1 41", bus.outValid, bus.outChar);
    end
    step(1'b0, 8'h00, 1'b1, acc);
    checks++;
    if (bus.outValid !== 1'b0 || bus.outChar !== 8'h00) begin
      failures++;
      $display("FAIL latency_empty: got valid=%b char=%02h, want 0 00", bus.outValid, bus.outChar);
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL latency_stream: diff at %0d got_len=%0d want_len=%0d", d, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_subst();
    logic [7:0] seq [4] = '{8'h7F, 8'h0A, 8'h80, 8'h7E};
    int d;
    do_reset(1'b0, 1'b0);
    foreach (seq[i]) push_byte(seq[i], 1'b1);
    drain();
    d = first_diff();
    checks++;
    if (d != -1 || obs_q.size() != 4 || obs_q[0] !== 8'h23 || obs_q[3] !== 8'h7E) begin
      failures++;
      $display("FAIL subst_stream: diff at %0d got_len=%0d want 23 23 23 7e", d, obs_q.size());
    end
    checks++;
    if (bus.subCount !== 8'd3) begin
      failures++;
      $display("FAIL subst_count: got %0d want 3", bus.subCount);
    end
  endtask

  task automatic test_line();
    int d;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push_byte(8'(8'h30 + i), 1'b1);
    push_byte(8'h55, 1'b1);
    drain();
    d = first_diff();
    checks++;
    if (d != -1 || obs_q.size() != 19 || obs_q[16] !== 8'h0D || obs_q[17] !== 8'h0A || obs_q[18] !== 8'h55) begin
      failures++;
      $display("FAIL line_stream: diff at %0d got_len=%0d want_len=19", d, obs_q.size());
    end
    checks++;
    if (bus.lineCount !== 8'd1) begin
      failures++;
      $display("FAIL line_count: got %0d want 1", bus.lineCount);
    end
  endtask

  task automatic test_full();
    logic acc;
    int n_acc;
    int d;
    do_reset(1'b0, 1'b0);
    n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 8'(8'h61 + n_acc), 1'b0, acc);
      if (acc) n_acc++;
    end
    checks++;
    if (n_acc != 16 || bus.inReady !== 1'b0) begin
      failures++;
      $display("FAIL full_accept: got accepted=%0d ready=%b want 16 0", n_acc, bus.inReady);
    end
    step(1'b1, 8'h71, 1'b1, acc);
    checks++;
    if (acc !== 1'b0) begin
      failures++;
      $display("FAIL full_no_pushthrough: got accept=%b want 0", acc);
    end
    step(1'b1, 8'h71, 1'b1, acc);
    checks++;
    if (acc !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop: got accept=%b want 1", acc);
    end
    drain();
    d = first_diff();
    checks++;
    if (d != -1 || obs_q.size() != 19) begin
      failures++;
      $display("FAIL full_stream: diff at %0d got_len=%0d want_len=19", d, obs_q.size());
    end
  endtask

  task automatic test_cr_hold();
    logic acc;
    int n;
    int d;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push_byte(8'(8'h41 + i), 1'b0);
    n = 0;
    while (obs_q.size() < 16 && n < 100) begin
      step(1'b0, 8'h00, 1'b1, acc);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.outValid !== 1'b1 || bus.outChar !== 8'h0D) begin
        failures++;
        $display("FAIL cr_hold cycle %0d: got valid=%b char=%02h want 1 0d", k, bus.outValid, bus.outChar);
      end
      step(1'b0, 8'h00, 1'b0, acc);
    end
    checks++;
    if (obs_q.size() != 16) begin
      failures++;
      $display("FAIL cr_hold_no_xfer: got %0d transfers want 16", obs_q.size());
    end
    drain();
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL cr_hold_stream: diff at %0d got_len=%0d want_len=%0d", d, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] seq [7] = '{8'h41, 8'h01, 8'h42, 8'hFF, 8'h43, 8'h44, 8'h45};
    int d;
    do_reset(1'b0, 1'b0);
    foreach (seq[i]) push_byte(seq[i], 1'b1);
    drain();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i), 1'b0);
    checks++;
    if (bus.subCount !== 8'd2 || bus.outValid !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: got sub=%0d valid=%b want 2 1", bus.subCount, bus.outValid);
    end
    do_reset(1'b1, 1'b1);
    checks++;
    if (bus.outValid !== 1'b0 || bus.outChar !== 8'h00 || bus.subCount !== 8'h00 ||
        bus.lineCount !== 8'h00 || bus.inReady !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b char=%02h sub=%0d lines=%0d ready=%b want 0 00 0 0 1",
               bus.outValid, bus.outChar, bus.subCount, bus.lineCount, bus.inReady);
    end
    for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(32, 126)), 1'b1);
    drain();
    d = first_diff();
    checks++;
    if (d != -1 || obs_q.size() != 18 || obs_q[15] === 8'h0D || obs_q[16] !== 8'h0D) begin
      failures++;
      $display("FAIL mid_stream: diff at %0d got_len=%0d want_len=18", d, obs_q.size());
    end
  endtask

  task automatic test_random();
    logic acc;
    int d;
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0), acc);
    end
    drain();
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL random_stream: diff at %0d got_len=%0d want_len=%0d", d, obs_q.size(), exp_q.size());
    end
    checks++;
    if (bus.subCount !== 8'(sub_m) || bus.lineCount !== 8'(acc_total / LINE_LEN)) begin
      failures++;
      $display("FAIL random_counts: got sub=%0d lines=%0d want %0d %0d",
               bus.subCount, bus.lineCount, sub_m, acc_total / LINE_LEN);
    end
    checks++;
    if (idle_bad != 0) begin
      failures++;
      $display("FAIL random_idle_char: got %0d nonzero idle chars want 0", idle_bad);
    end
  endtask

  task automatic test_saturation();
    int d;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 4112; i++) begin
      if (i < 300) push_byte(8'($urandom_range(0, 31)), 1'b1);
      else         push_byte(8'($urandom_range(32, 126)), 1'b1);
    end
    drain();
    d = first_diff();
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL sat_stream: diff at %0d got_len=%0d want_len=%0d", d, obs_q.size(), exp_q.size());
    end
    checks++;
    if (bus.subCount !== 8'd255 || bus.lineCount !== 8'(acc_total / LINE_LEN)) begin
      failures++;
      $display("FAIL sat_counts: got sub=%0d lines=%0d want 255 %0d",
               bus.subCount, bus.lineCount, (acc_total / LINE_LEN) % 256);
    end
  endtask

  initial begin
    bus.inValid  = 1'b0;
    bus.inByte   = 8'h00;
    bus.outReady = 1'b0;
    model_reset();
    test_reset();
    test_latency();
    test_subst();
    test_line();
    test_full();
    test_cr_hold();
    test_mid_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
